fetch_unit: RTL

Instruction fetch front end for the pipelined RV32 core. It owns the fetch PC and drives the address of the combinational word-aligned instruction memory. It captures each returned word, with its PC, into a small in-order buffer. The buffer feeds decode through a valid/ready handshake, and the unit supports branch/jump redirect with buffer flush.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the core front end.
//   XLEN / ILEN   : data and instruction widths
//   NOP_INSTR     : canonical RV32 NOP (addi x0,x0,0), used by decode for bubbles
//   fetch_entry_t : one fetched instruction together with its PC
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer between fetch and decode.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write one entry (ignored when flushing, or when full without pop)
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard every entry; a pop in the same cycle still counts
//   head_valid : buffer is non-empty
//   head       : head entry, all zeros when empty
//   count      : number of entries held
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output logic                     head_valid,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_reg [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic            pop_en;
  logic            push_en;

  assign pop_en  = pop && (count_reg != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push_en = push && !flush && ((count_reg < CW'(DEPTH)) || pop_en);

  // Entry storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_valid = (count_reg != '0);
  assign head       = head_valid ? mem_reg[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, captures words from a
// combinational instruction memory into an in-order buffer, and hands them
// to decode over valid/ready. Redirects flush the buffer and reload the PC.
//   imem_addr / imem_instr         : instruction memory address and returned word
//   redirect_valid / redirect_pc   : branch/jump redirect from execute
//   out_valid/out_pc/out_instr     : head of buffer towards decode (zeros when empty)
//   out_ready                      : decode accepts the head this cycle
//   fetch_count                    : completed decode handshakes since reset (wraps)
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic [31:0] fetch_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [31:0]     fetch_count_reg;

  logic            pop;
  logic            push;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [CW-1:0]   buf_count;
  logic [1:0]      unused_redirect_lsb;

  // Targets are word aligned; the low bits of the request are dropped.
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign pop  = head_valid && out_ready;
  assign push = !redirect_valid && ((buf_count < CW'(DEPTH)) || pop);

  assign push_entry.pc    = fetch_pc_reg;
  assign push_entry.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .din        (push_entry),
    .head_valid (head_valid),
    .head       (head),
    .count      (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      fetch_count_reg <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      // The handshake in a redirect cycle still completes and is counted.
      if (pop) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  assign imem_addr   = fetch_pc_reg;
  assign out_valid   = head_valid;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign fetch_count = fetch_count_reg;

endmodule
